// File: rtl/reg_wb_arbiter_if.sv
// Bus bundle between the pipeline/long-latency unit and the register-file write arbiter.
// Optional macro ARB_STATS_EN adds the arb_conflict_cnt statistics signal.
interface reg_wb_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        rs_busy1;
  logic        rs_busy2;
  logic        arb_stall;
  logic [4:0]  REG_address_wr;
  logic        REG_write_enable;
  logic [31:0] REG_write_data;
`ifdef ARB_STATS_EN
  logic [15:0] arb_conflict_cnt;

  modport slave (
    input  wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
           lu_issue, lu_issue_addr, rd_addr1, rd_addr2,
    output lu_ready, rs_busy1, rs_busy2, arb_stall,
           REG_address_wr, REG_write_enable, REG_write_data, arb_conflict_cnt
  );

  modport master (
    output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
           lu_issue, lu_issue_addr, rd_addr1, rd_addr2,
    input  lu_ready, rs_busy1, rs_busy2, arb_stall,
           REG_address_wr, REG_write_enable, REG_write_data, arb_conflict_cnt
  );
`else
  modport slave (
    input  wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
           lu_issue, lu_issue_addr, rd_addr1, rd_addr2,
    output lu_ready, rs_busy1, rs_busy2, arb_stall,
           REG_address_wr, REG_write_enable, REG_write_data
  );

  modport master (
    output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
           lu_issue, lu_issue_addr, rd_addr1, rd_addr2,
    input  lu_ready, rs_busy1, rs_busy2, arb_stall,
           REG_address_wr, REG_write_enable, REG_write_data
  );
`endif
endinterface

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, long-latency results queue
// in a FIFO with a starvation-forced stall, plus a busy scoreboard. Optional: ARB_STATS_EN.
module reg_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            SYS_reset,
  reg_wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    r_fifo_addr [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_stall;
  logic [31:0]   r_busy;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_wb_grant;
  logic [4:0]    w_head_addr;
  logic [31:0]   w_head_data;
  logic [31:0]   w_busy_next;
  logic          w_we;
  logic [4:0]    w_waddr;
  logic [31:0]   w_wdata;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // Reset gates every grant so nothing reaches the register file while it is asserted.
  assign w_wb_grant  = !SYS_reset && bus.wb_valid && !r_stall;
  assign w_pop       = !SYS_reset && !w_empty && !w_wb_grant;
  assign bus.lu_ready = !w_full && !SYS_reset;
  assign w_push      = bus.lu_valid && bus.lu_ready;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (w_wb_grant) begin
      w_waddr = bus.wb_addr;
      w_wdata = bus.wb_data;
      w_we    = (bus.wb_addr != 5'd0);
    end else if (w_pop) begin
      w_waddr = w_head_addr;
      w_wdata = w_head_data;
      w_we    = (w_head_addr != 5'd0);
    end
  end

  assign bus.REG_write_enable = w_we;
  assign bus.REG_address_wr   = w_waddr;
  assign bus.REG_write_data   = w_wdata;
  assign bus.arb_stall        = r_stall;

  // Storage is written only on push; pointers alone define validity, so no reset here.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.lu_addr;
      r_fifo_data[r_wr_ptr] <= bus.lu_data;
    end
  end

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The stall lasts one cycle: during it wb cannot win, so the head pops and the counter clears.
  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_empty || w_pop) r_starve <= '0;
      else                  r_starve <= r_starve + SW'(1);
      r_stall <= !w_empty && !w_pop && (r_starve == SW'(STARVE_MAX - 1));
    end
  end

  // Issue is applied after the pop-clear so a same-address set wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop)        w_busy_next[w_head_addr]       = 1'b0;
    if (bus.lu_issue) w_busy_next[bus.lu_issue_addr] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) r_busy <= '0;
    else           r_busy <= w_busy_next;
  end

  assign bus.rs_busy1 = r_busy[bus.rd_addr1];
  assign bus.rs_busy2 = r_busy[bus.rd_addr2];

`ifdef ARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset)                 r_conflict_cnt <= '0;
    else if (w_wb_grant && !w_empty) r_conflict_cnt <= sat_inc16(r_conflict_cnt);
  end

  assign bus.arb_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter: inputs change 1ns after posedge,
// outputs are sampled at negedge, where the register file would latch them.
module tb_reg_wb_arbiter;

  logic clk = 1'b0;
  logic SYS_reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter_if bus();

  reg_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk       (clk),
    .SYS_reset (SYS_reset),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.lu_valid = 0; bus.lu_addr = 0; bus.lu_data = 0;
    bus.lu_issue = 0; bus.lu_issue_addr = 0;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    bus.lu_valid = 1; bus.lu_addr = a; bus.lu_data = d;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"},   {31'd0, bus.REG_write_enable}, 32'd1);
    check({tag, "_addr"}, {27'd0, bus.REG_address_wr},   {27'd0, a});
    check({tag, "_data"}, bus.REG_write_data,            d);
  endtask

  initial begin
    idle_inputs();
    bus.rd_addr1 = 0; bus.rd_addr2 = 0;

    // Reset held, with an illegal-in-reset wb request present
    bus.wb_valid = 1; bus.wb_addr = 3; bus.wb_data = 32'h11;
    mid();
    check("rst_we",    {31'd0, bus.REG_write_enable}, 32'd0);
    check("rst_ready", {31'd0, bus.lu_ready},         32'd0);
    check("rst_addr",  {27'd0, bus.REG_address_wr},   32'd0);
    check("rst_data",  bus.REG_write_data,            32'd0);

    cyc(); SYS_reset = 0; idle_inputs();
    mid();
    check("idle_we",    {31'd0, bus.REG_write_enable}, 32'd0);
    check("idle_ready", {31'd0, bus.lu_ready},         32'd1);
    check("idle_busy1", {31'd0, bus.rs_busy1},         32'd0);
    check("idle_busy2", {31'd0, bus.rs_busy2},         32'd0);
    check("idle_stall", {31'd0, bus.arb_stall},        32'd0);

    // Scoreboard: issue 5, push two cycles later, commit one cycle after push
    cyc(); bus.lu_issue = 1; bus.lu_issue_addr = 5; bus.rd_addr1 = 5;
    mid(); check("sb_not_yet", {31'd0, bus.rs_busy1}, 32'd0);
    cyc(); bus.lu_issue = 0;
    mid(); check("sb_set", {31'd0, bus.rs_busy1}, 32'd1);
    cyc(); push(5, 32'hDEADBEEF);
    mid();
    check("sb_hold",    {31'd0, bus.rs_busy1},         32'd1);
    check("no_fallthr", {31'd0, bus.REG_write_enable}, 32'd0);
    cyc(); idle_inputs();
    mid();
    expect_write("lu_commit", 5, 32'hDEADBEEF);
    check("sb_still", {31'd0, bus.rs_busy1}, 32'd1);
    cyc();
    mid();
    check("sb_clear",  {31'd0, bus.rs_busy1},         32'd0);
    check("post_we",   {31'd0, bus.REG_write_enable}, 32'd0);

    // Starvation: wb saturates, queued addr 7 forced out on the 9th cycle
    cyc(); bus.wb_valid = 1; bus.wb_addr = 3; bus.wb_data = 32'h11; push(7, 32'h77);
    mid(); expect_write("wb_first", 3, 32'h11);
    cyc(); bus.lu_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      mid();
      check($sformatf("wb_win%0d_addr", i),  {27'd0, bus.REG_address_wr}, 32'd3);
      check($sformatf("wb_win%0d_stall", i), {31'd0, bus.arb_stall},      32'd0);
      cyc();
    end
    mid();
    check("starve_stall", {31'd0, bus.arb_stall}, 32'd1);
    expect_write("starve_pop", 7, 32'h77);
    cyc();
    mid();
    check("stall_gone", {31'd0, bus.arb_stall}, 32'd0);
    expect_write("wb_resume", 3, 32'h11);

    // Fill FIFO behind wb, then drain with a push/pop overlap
    cyc(); push(10, 32'hA0);
    cyc(); push(11, 32'hA1);
    cyc(); push(12, 32'hA2);
    cyc(); push(13, 32'hA3);
    mid(); check("fill3_ready", {31'd0, bus.lu_ready}, 32'd1);
    cyc(); push(14, 32'hA4);
    mid(); check("full_ready", {31'd0, bus.lu_ready}, 32'd0);
    cyc(); bus.wb_valid = 0;
    mid();
    check("full_ready2", {31'd0, bus.lu_ready}, 32'd0);
    expect_write("drain0", 10, 32'hA0);
    cyc();
    mid();
    check("pp_ready", {31'd0, bus.lu_ready}, 32'd1);
    expect_write("drain1", 11, 32'hA1);
    cyc(); bus.lu_valid = 0;
    mid(); expect_write("drain2", 12, 32'hA2);
    cyc();
    mid(); expect_write("drain3", 13, 32'hA3);
    cyc();
    mid(); expect_write("drain4", 14, 32'hA4);
    cyc();
    mid(); check("drained_we", {31'd0, bus.REG_write_enable}, 32'd0);

    // Address 0: head popped without a write; wb to r0 suppressed; r0 never busy
    cyc(); push(0, 32'h55); bus.lu_issue = 1; bus.lu_issue_addr = 0; bus.rd_addr1 = 0;
    cyc(); push(9, 32'h99); bus.lu_issue = 0;
    mid();
    check("a0_pop_we", {31'd0, bus.REG_write_enable}, 32'd0);
    check("a0_busy",   {31'd0, bus.rs_busy1},         32'd0);
    cyc(); bus.lu_valid = 0;
    mid(); expect_write("a0_next", 9, 32'h99);
    cyc(); bus.wb_valid = 1; bus.wb_addr = 0; bus.wb_data = 32'h66;
    mid(); check("a0_wb_we", {31'd0, bus.REG_write_enable}, 32'd0);
    cyc(); idle_inputs();

`ifdef ARB_STATS_EN
    // Reset clears the counter so this section starts from a known value
    SYS_reset = 1; #1 SYS_reset = 0;
    cyc(); push(21, 32'h21);
    cyc(); bus.lu_valid = 0; bus.wb_valid = 1; bus.wb_addr = 4; bus.wb_data = 32'h44;
    cyc();
    cyc();
    cyc(); bus.wb_valid = 0;
    mid();
    expect_write("stat_pop", 21, 32'h21);
    check("stat_cnt3", {16'd0, bus.arb_conflict_cnt}, 32'd3);
    cyc();
    mid(); check("stat_hold", {16'd0, bus.arb_conflict_cnt}, 32'd3);
`endif

    // Reset mid-run discards the queued entry and busy bit immediately
    cyc(); idle_inputs(); bus.lu_issue = 1; bus.lu_issue_addr = 20; push(20, 32'hAB);
    bus.rd_addr1 = 20;
    cyc(); idle_inputs();
    SYS_reset = 1;
    #1;
    check("mr_we",    {31'd0, bus.REG_write_enable}, 32'd0);
    check("mr_ready", {31'd0, bus.lu_ready},         32'd0);
    check("mr_busy",  {31'd0, bus.rs_busy1},         32'd0);
    check("mr_stall", {31'd0, bus.arb_stall},        32'd0);
`ifdef ARB_STATS_EN
    check("mr_cnt",   {16'd0, bus.arb_conflict_cnt}, 32'd0);
`endif
    cyc(); SYS_reset = 0;
    mid();
    check("mr_empty", {31'd0, bus.REG_write_enable}, 32'd0);
    check("mr_busy2", {31'd0, bus.rs_busy1},         32'd0);
    check("mr_ready2", {31'd0, bus.lu_ready},        32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
